// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers, fixed 5-cycle multiply and
// 10-cycle divide latency, and direct HI/LO moves.
module md_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [3:0] MUL_CNT = 4'd4;
  localparam logic [3:0] DIV_CNT = 4'd9;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              done_nxt;
  logic              commit;
  logic              load;
  logic              expire;
  logic              accept;
  logic [1:0]        op_p0;
  logic [DATA_W-1:0] rs_p0, rt_p0;
  logic [2*DATA_W-1:0] mul_res_p1;
  logic [2*DATA_W-1:0] div_res_p1;

  // Full-width product; sign extension into the upper half makes one unsigned
  // multiply serve both the signed and unsigned forms.
  function automatic logic [2*DATA_W-1:0] mul_full(input logic sgn,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] ea, eb;
    ea = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    eb = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so the
  // most-negative / -1 case wraps to the most-negative quotient with no overflow.
  function automatic logic [2*DATA_W-1:0] div_full(input logic sgn,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] ma, mb, q, r;
    ma = (sgn && a[DATA_W-1]) ? -a : a;
    mb = (sgn && b[DATA_W-1]) ? -b : b;
    q  = (mb == '0) ? '0 : ma / mb;
    r  = (mb == '0) ? '0 : ma % mb;
    if (sgn && (a[DATA_W-1] ^ b[DATA_W-1])) q = -q;
    if (sgn && a[DATA_W-1]) r = -r;
    return {r, q};
  endfunction

  assign busy   = (state != IDLE);
  assign expire = busy && (cnt == 4'd0);
  // A new request is taken when idle or on the edge the current one commits.
  assign accept = start && (md_op <= OP_MTLO) && (!busy || expire);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    commit    = 1'b0;
    load      = 1'b0;
    if (busy) begin
      if (expire) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        commit    = 1'b1;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
    end
    if (accept && !md_op[2]) begin
      load      = 1'b1;
      state_nxt = md_op[1] ? DIV : MUL;
      cnt_nxt   = md_op[1] ? DIV_CNT : MUL_CNT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  // Operand capture stage
  always_ff @(posedge clk) begin
    if (load) begin
      op_p0 <= md_op[1:0];
      rs_p0 <= rs_data;
      rt_p0 <= rt_data;
    end
  end

  // Result stage
  assign mul_res_p1 = mul_full(~op_p0[0], rs_p0, rt_p0);
  assign div_res_p1 = div_full(~op_p0[0], rs_p0, rt_p0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (commit) begin
        if (!op_p0[1]) begin
          {hi, lo} <= mul_res_p1;
        end else if (rt_p0 != '0) begin
          {hi, lo} <= div_res_p1;
        end
      end
      if (accept && md_op == OP_MTHI) hi <= rs_data;
      if (accept && md_op == OP_MTLO) lo <= rs_data;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, results, moves, reset.
module tb_md_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    md_op   = op;
    rs_data = a;
    rt_data = b;
  endtask

  // Issue an op, scramble the operand inputs after the accepting edge, check
  // busy on every in-flight cycle, and stop right after the commit edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat);
    issue(op, a, b);
    tick();
    start   = 1'b0;
    rs_data = ~a;
    rt_data = ~b;
    chk({tag, "_busy_0"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_busy_n"}, {31'd0, busy}, 32'd1);
    end
    tick();
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    md_op   = 3'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // First edge after reset release accepts mthi
    reset = 1'b1;
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    tick();
    start = 1'b0;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd0);

    // mult -2 * 3, operands changed after accept, mtlo attempted while busy
    issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    tick();
    chk("mult_busy_0", {31'd0, busy}, 32'd1);
    issue(OP_MTLO, 32'h0000_BEEF, 32'hCAFE_F00D);
    tick();
    start   = 1'b0;
    rs_data = 32'hDEAD_BEEF;
    chk("mtlo_ignored", lo, 32'd0);
    chk("mult_busy_1", {31'd0, busy}, 32'd1);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("mult_busy_n", {31'd0, busy}, 32'd1);
      chk("mult_hi_held", hi, 32'h1234_5678);
    end
    tick();
    chk("mult_busy_end", {31'd0, busy}, 32'd0);
    chk("mult_done", {31'd0, done}, 32'd1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    tick();
    chk("mult_done_pulse", {31'd0, done}, 32'd0);
    chk("mtlo_never_applied", lo, 32'hFFFF_FFFA);

    // multu max*max with a back-to-back mult issued on its commit edge
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    start   = 1'b0;
    rs_data = 32'd2;
    rt_data = 32'd2;
    for (int i = 1; i < 5; i++) begin
      chk("multu_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("multu_busy_last", {31'd0, busy}, 32'd1);
    issue(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD);
    tick();
    start   = 1'b0;
    rs_data = 32'd1;
    rt_data = 32'd1;
    chk("multu_done", {31'd0, done}, 32'd1);
    chk("b2b_busy_0", {31'd0, busy}, 32'd1);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("b2b_busy_n", {31'd0, busy}, 32'd1);
      chk("b2b_done_low", {31'd0, done}, 32'd0);
      chk("b2b_lo_held", lo, 32'h0000_0001);
    end
    tick();
    chk("b2b_busy_end", {31'd0, busy}, 32'd0);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_hi", hi, 32'hFFFF_FFFF);
    chk("b2b_lo", lo, 32'hFFFF_FFEB);

    // Signed and unsigned divides
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10);
    chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);
    run_op("divu_z", OP_DIVU, 32'h0000_0007, 32'h0000_0000, 10);
    chk("divu_z_lo", lo, 32'h8000_0000);
    chk("divu_z_hi", hi, 32'h0000_0000);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 10);
    chk("divu_100_7_lo", lo, 32'd14);
    chk("divu_100_7_hi", hi, 32'd2);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10);
    chk("div_7_m2_lo", lo, 32'hFFFF_FFFD);
    chk("div_7_m2_hi", hi, 32'd1);

    // Reserved opcode is ignored
    issue(3'd6, 32'hAAAA_AAAA, 32'd1);
    tick();
    start = 1'b0;
    chk("rsv_busy", {31'd0, busy}, 32'd0);
    chk("rsv_hi", hi, 32'd1);
    chk("rsv_lo", lo, 32'hFFFF_FFFD);
    tick();
    chk("rsv_done", {31'd0, done}, 32'd0);

    // Asynchronous reset in the middle of a divide
    issue(OP_DIV, 32'd100, 32'd3);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("arst_pre_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("arst_no_done", {31'd0, done}, 32'd0);
      chk("arst_no_busy", {31'd0, busy}, 32'd0);
    end
    chk("arst_hi_after", hi, 32'd0);
    chk("arst_lo_after", lo, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request to issue md_op this cycle.
REQ-004 SHALL have port: md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
REQ-005 SHALL have port: rs_data  input  32  first operand (multiplicand / dividend / mthi-mtlo source).
REQ-006 SHALL have port: rt_data  input  32  second operand (multiplier / divisor).
REQ-007 SHALL have port: busy  output  1  operation in flight.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when a mult/div result commits.
REQ-009 SHALL have port: hi  output  32  HI register.
REQ-010 SHALL have port: lo  output  32  LO register.

Function
REQ-011 SHALL sample start, md_op, rs_data and rt_data only on a rising clk edge where busy=0.
REQ-012 SHALL ignore start while busy=1: no state change, no operand capture.
REQ-013 SHALL ignore start with reserved md_op: no state change.
REQ-014 SHALL, for mthi/mtlo accepted at edge N, write rs_data into hi/lo at edge N; busy and done stay 0.
REQ-015 SHALL have states IDLE, MUL and DIV; IDLE->MUL on accepted mult/multu, IDLE->DIV on accepted div/divu, MUL/DIV->IDLE when the cycle counter expires.
REQ-016 SHALL capture operands at the accepting edge; later changes on rs_data/rt_data SHALL NOT affect the result.
REQ-017 SHALL hold busy=1 for exactly 5 cycles after an accepted mult/multu and exactly 10 cycles after an accepted div/divu.
REQ-018 SHALL, at edge N+5 (mult) or N+10 (div), update hi/lo, drive busy=0, and pulse done=1 for one cycle.
REQ-019 SHALL keep hi/lo at their previous values while busy=1.
REQ-020 SHALL compute mult as the signed 64-bit product; hi = bits 63:32, lo = bits 31:0.
REQ-021 SHALL compute multu as the unsigned 64-bit product, split the same way.
REQ-022 SHALL compute div as signed: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
REQ-023 SHALL compute divu as unsigned: lo = quotient, hi = remainder.
REQ-024 SHALL, for div 0x80000000 / 0xFFFFFFFF, give lo=0x80000000, hi=0x00000000.
REQ-025 SHALL, for divisor zero (div or divu), run the full 10-cycle latency, leave hi/lo unchanged, and still pulse done.
REQ-026 SHALL accept a new start on the same edge that done is asserted: busy stays 1 for the new operation.

Reset
REQ-027 SHALL, while reset=0, immediately force state IDLE, busy=0, done=0, hi=0, lo=0 and the cycle counter to 0, independent of clk.
REQ-028 SHALL discard an in-flight operation on reset with no later commit.
REQ-029 SHALL accept a start on the first rising edge after reset returns to 1.

Verification
REQ-030 SHALL cover: mult rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for 1 cycle.
REQ-031 SHALL cover: multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL cover: div rs=0xFFFFFFF9 (-7), rt=0x00000002 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7, rt=0 -> hi/lo unchanged, done pulses.
REQ-033 SHALL cover: mthi rs=0x12345678 while idle -> hi=0x12345678 next edge, busy stays 0; mtlo issued during busy -> ignored, lo unchanged.
REQ-034 SHALL cover: reset=0 asserted at cycle 3 of a div -> busy=0, hi=lo=0 without a clk edge; no done afterwards.
REQ-035 SHALL cover: operands changed on the cycle after start, plus back-to-back mult issued on the done edge -> results use the captured operands, and the second busy window is exactly 5 cycles.
